// File: rtl/turn_if.sv
// turn_if: bundles the keyboard/projectile inputs and the turn-status outputs
// exchanged between the turn controller and its environment.
//   keycode        current keyboard keycode, 0 = none
//   proj_done      1-frame pulse: projectile resolved
//   hit_p1/hit_p2  projectile struck player 1 / player 2 (valid with proj_done)
//   is_in_turn_p1/is_in_turn_p2  player may move
//   fire           1-frame launch pulse for active_player
//   active_player  0 = player 1, 1 = player 2
//   sec_left       turn seconds remaining
//   hp_p1/hp_p2    hit points
//   game_over      game finished
//   winner         00 none, 01 p1, 10 p2, 11 draw
// master drives the inputs of the controller, slave is the controller itself.
interface turn_if;
  logic [7:0] keycode;
  logic       proj_done;
  logic       hit_p1;
  logic       hit_p2;
  logic       is_in_turn_p1;
  logic       is_in_turn_p2;
  logic       fire;
  logic       active_player;
  logic [5:0] sec_left;
  logic [2:0] hp_p1;
  logic [2:0] hp_p2;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output keycode, proj_done, hit_p1, hit_p2,
    input  is_in_turn_p1, is_in_turn_p2, fire, active_player,
           sec_left, hp_p1, hp_p2, game_over, winner
  );

  modport slave (
    input  keycode, proj_done, hit_p1, hit_p2,
    output is_in_turn_p1, is_in_turn_p2, fire, active_player,
           sec_left, hp_p1, hp_p2, game_over, winner
  );
endinterface

// File: rtl/turn_controller.sv
// turn_controller: two-player turn sequencer running at frame rate.
// Grants movement to one player at a time, times each turn, detects the
// fire key, waits for the projectile to resolve, tracks hit points and
// declares the winner.
// Ports:
//   frame_clk  frame-rate clock, all state changes on posedge
//   Reset_n    asynchronous active-low reset
//   bus        turn_if.slave (keyboard/projectile inputs, turn-status outputs)
module turn_controller #(
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         TURN_SECS      = 10,
  parameter int         SWITCH_FRAMES  = 30,
  parameter int         HP_INIT        = 3,
  parameter logic [7:0] FIRE_KEY       = 8'd44,
  parameter logic [7:0] START_KEY      = 8'd40
) (
  input  logic  frame_clk,
  input  logic  Reset_n,
  turn_if.slave bus
);

  // frame_cnt serves both the per-second divider and the switch delay
  localparam int CNT_MAX = (FRAMES_PER_SEC > SWITCH_FRAMES) ? FRAMES_PER_SEC : SWITCH_FRAMES;
  localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_MOVE      = 3'd1,
    ST_PROJ      = 3'd2,
    ST_SWITCH    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               active_player, active_player_nxt;
  logic [5:0]         sec_left, sec_left_nxt;
  logic [2:0]         hp_p1, hp_p1_nxt;
  logic [2:0]         hp_p2, hp_p2_nxt;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [7:0]         key_prev;
  logic [1:0]         winner, winner_nxt;
  logic               fire, fire_nxt;
  logic               turn_p1, turn_p1_nxt;
  logic               turn_p2, turn_p2_nxt;
  logic               game_over, game_over_nxt;

  logic               start_press;
  logic               fire_press;
  logic               sec_wrap;
  logic               switch_done;
  logic [2:0]         hp_p1_hit;
  logic [2:0]         hp_p2_hit;

  // Saturating hit-point decrement
  function automatic logic [2:0] hp_dec(input logic [2:0] hp, input logic hit);
    logic [2:0] res;
    if (hit && (hp != 3'd0)) begin
      res = hp - 3'd1;
    end else begin
      res = hp;
    end
    return res;
  endfunction

  // Edge-detected key presses: a held key yields one press
  assign start_press = (bus.keycode == START_KEY) && (key_prev != START_KEY);
  assign fire_press  = (bus.keycode == FIRE_KEY)  && (key_prev != FIRE_KEY);
  assign sec_wrap    = (frame_cnt == CNT_W'(FRAMES_PER_SEC - 1));
  assign switch_done = (frame_cnt == CNT_W'(SWITCH_FRAMES - 1));
  assign hp_p1_hit   = hp_dec(hp_p1, bus.hit_p1);
  assign hp_p2_hit   = hp_dec(hp_p2, bus.hit_p2);

  // Next-state and next-output logic
  always_comb begin
    state_nxt         = state;
    active_player_nxt = active_player;
    sec_left_nxt      = sec_left;
    hp_p1_nxt         = hp_p1;
    hp_p2_nxt         = hp_p2;
    frame_cnt_nxt     = frame_cnt;
    winner_nxt        = winner;
    fire_nxt          = 1'b0;

    case (state)
      ST_START: begin
        if (start_press) begin
          state_nxt         = ST_MOVE;
          sec_left_nxt      = 6'(TURN_SECS);
          frame_cnt_nxt     = '0;
          active_player_nxt = 1'b0;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_MOVE: begin
        // Fire takes priority over a timeout on the same frame; timer freezes
        if (fire_press) begin
          fire_nxt  = 1'b1;
          state_nxt = ST_PROJ;
        end else if (sec_wrap) begin
          frame_cnt_nxt = '0;
          if (sec_left == 6'd0) begin
            state_nxt = ST_SWITCH;
          end else begin
            sec_left_nxt = sec_left - 6'd1;
          end
        end else begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
        end
      end
      ST_PROJ: begin
        if (bus.proj_done) begin
          hp_p1_nxt     = hp_p1_hit;
          hp_p2_nxt     = hp_p2_hit;
          frame_cnt_nxt = '0;
          if ((hp_p1_hit == 3'd0) || (hp_p2_hit == 3'd0)) begin
            state_nxt  = ST_GAME_OVER;
            // bit1: player 2 wins (p1 dead), bit0: player 1 wins (p2 dead)
            winner_nxt = {(hp_p1_hit == 3'd0), (hp_p2_hit == 3'd0)};
          end else begin
            state_nxt = ST_SWITCH;
          end
        end else begin
          state_nxt = ST_PROJ;
        end
      end
      ST_SWITCH: begin
        if (switch_done) begin
          state_nxt         = ST_MOVE;
          active_player_nxt = ~active_player;
          sec_left_nxt      = 6'(TURN_SECS);
          frame_cnt_nxt     = '0;
        end else begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (start_press) begin
          state_nxt         = ST_MOVE;
          hp_p1_nxt         = 3'(HP_INIT);
          hp_p2_nxt         = 3'(HP_INIT);
          winner_nxt        = 2'b00;
          active_player_nxt = 1'b0;
          sec_left_nxt      = 6'(TURN_SECS);
          frame_cnt_nxt     = '0;
        end else begin
          state_nxt = ST_GAME_OVER;
        end
      end
      default: begin
        state_nxt         = ST_START;
        active_player_nxt = 1'b0;
        sec_left_nxt      = 6'(TURN_SECS);
        hp_p1_nxt         = 3'(HP_INIT);
        hp_p2_nxt         = 3'(HP_INIT);
        frame_cnt_nxt     = '0;
        winner_nxt        = 2'b00;
      end
    endcase

    // Status flags are registered copies of the next-state decode
    turn_p1_nxt   = (state_nxt == ST_MOVE) && !active_player_nxt;
    turn_p2_nxt   = (state_nxt == ST_MOVE) &&  active_player_nxt;
    game_over_nxt = (state_nxt == ST_GAME_OVER);
  end

  // State and output registers
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_START;
      active_player <= 1'b0;
      sec_left      <= 6'(TURN_SECS);
      hp_p1         <= 3'(HP_INIT);
      hp_p2         <= 3'(HP_INIT);
      frame_cnt     <= '0;
      key_prev      <= 8'd0;
      winner        <= 2'b00;
      fire          <= 1'b0;
      turn_p1       <= 1'b0;
      turn_p2       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_nxt;
      active_player <= active_player_nxt;
      sec_left      <= sec_left_nxt;
      hp_p1         <= hp_p1_nxt;
      hp_p2         <= hp_p2_nxt;
      frame_cnt     <= frame_cnt_nxt;
      key_prev      <= bus.keycode;
      winner        <= winner_nxt;
      fire          <= fire_nxt;
      turn_p1       <= turn_p1_nxt;
      turn_p2       <= turn_p2_nxt;
      game_over     <= game_over_nxt;
    end
  end

  assign bus.is_in_turn_p1 = turn_p1;
  assign bus.is_in_turn_p2 = turn_p2;
  assign bus.fire          = fire;
  assign bus.active_player = active_player;
  assign bus.sec_left      = sec_left;
  assign bus.hp_p1         = hp_p1;
  assign bus.hp_p2         = hp_p2;
  assign bus.game_over     = game_over;
  assign bus.winner        = winner;

endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed self-checking bench for turn_controller with
// FRAMES_PER_SEC=4, TURN_SECS=3, SWITCH_FRAMES=2, HP_INIT=2.
module tb_turn_controller;
  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  turn_if bus();

  turn_controller #(
    .FRAMES_PER_SEC(4),
    .TURN_SECS     (3),
    .SWITCH_FRAMES (2),
    .HP_INIT       (2),
    .FIRE_KEY      (8'd44),
    .START_KEY     (8'd40)
  ) dut (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Fire press for one frame, then release
  task automatic do_fire();
    bus.keycode = 8'd44;
    tick();
    bus.keycode = 8'd0;
  endtask

  // One-frame projectile resolution with given hits
  task automatic resolve(input logic h1, input logic h2);
    bus.proj_done = 1'b1;
    bus.hit_p1    = h1;
    bus.hit_p2    = h2;
    tick();
    bus.proj_done = 1'b0;
    bus.hit_p1    = 1'b0;
    bus.hit_p2    = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.keycode = 8'd44;
    tick(); tick();
    tests_run++;
    if ({bus.is_in_turn_p1, bus.is_in_turn_p2, bus.fire, bus.active_player, bus.game_over} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.is_in_turn_p1, bus.is_in_turn_p2, bus.fire, bus.active_player, bus.game_over});
    end
    tests_run++;
    if ({bus.sec_left, bus.hp_p1, bus.hp_p2, bus.winner} !== {6'd3, 3'd2, 3'd2, 2'b00}) begin
      tests_failed++;
      $display("FAIL reset_values: got sec=%0d hp=%0d/%0d win=%b expected sec=3 hp=2/2 win=00",
               bus.sec_left, bus.hp_p1, bus.hp_p2, bus.winner);
    end
    Reset_n = 1'b1;
    tick();
    bus.keycode = 8'd0;
    tick();
    tests_run++;
    if (bus.is_in_turn_p1 !== 1'b0 || bus.fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignores_fire: got turn=%b fire=%b expected 0 0", bus.is_in_turn_p1, bus.fire);
    end
  endtask

  task automatic test_start();
    bus.keycode = 8'd40;
    tick();
    bus.keycode = 8'd0;
    tests_run++;
    if ({bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player, bus.sec_left} !== {3'b100, 6'd3}) begin
      tests_failed++;
      $display("FAIL start_move: got p1=%b p2=%b ap=%b sec=%0d expected 1 0 0 3",
               bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player, bus.sec_left);
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 15; k++) begin
      tick();
      tests_run++;
      if (bus.sec_left !== 6'(3 - k / 4) || bus.is_in_turn_p1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL timer_k%0d: got sec=%0d p1=%b expected sec=%0d p1=1",
                 k, bus.sec_left, bus.is_in_turn_p1, 3 - k / 4);
      end
    end
    tick();
    tests_run++;
    if (bus.is_in_turn_p1 !== 1'b0 || bus.is_in_turn_p2 !== 1'b0 || bus.fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_switch: got p1=%b p2=%b fire=%b expected 0 0 0",
               bus.is_in_turn_p1, bus.is_in_turn_p2, bus.fire);
    end
    tick();
    tests_run++;
    if (bus.is_in_turn_p2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL switch_hold: got p2=%b expected 0", bus.is_in_turn_p2);
    end
    tick();
    tests_run++;
    if ({bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player, bus.sec_left} !== {3'b011, 6'd3}) begin
      tests_failed++;
      $display("FAIL p2_turn: got p1=%b p2=%b ap=%b sec=%0d expected 0 1 1 3",
               bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player, bus.sec_left);
    end
  endtask

  task automatic test_fire_held();
    int fire_count = 0;
    bus.keycode = 8'd44;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fire === 1'b1) fire_count++;
      if (i == 0) begin
        tests_run++;
        if (bus.fire !== 1'b1 || bus.is_in_turn_p1 !== 1'b0 || bus.is_in_turn_p2 !== 1'b0) begin
          tests_failed++;
          $display("FAIL fire_first: got fire=%b p1=%b p2=%b expected 1 0 0",
                   bus.fire, bus.is_in_turn_p1, bus.is_in_turn_p2);
        end
      end
    end
    bus.keycode = 8'd0;
    tests_run++;
    if (fire_count != 1) begin
      tests_failed++;
      $display("FAIL fire_once: got %0d pulses expected 1", fire_count);
    end
    bus.hit_p1 = 1'b1;
    tick();
    bus.hit_p1 = 1'b0;
    tests_run++;
    if (bus.hp_p1 !== 3'd2) begin
      tests_failed++;
      $display("FAIL hit_unqualified: got hp_p1=%0d expected 2", bus.hp_p1);
    end
    resolve(1'b0, 1'b0);
    tests_run++;
    if ({bus.hp_p1, bus.hp_p2, bus.game_over, bus.is_in_turn_p1, bus.is_in_turn_p2} !== {3'd2, 3'd2, 3'b000}) begin
      tests_failed++;
      $display("FAIL miss_switch: got hp=%0d/%0d go=%b p1=%b p2=%b expected 2/2 0 0 0",
               bus.hp_p1, bus.hp_p2, bus.game_over, bus.is_in_turn_p1, bus.is_in_turn_p2);
    end
    tick(); tick();
    tests_run++;
    if (bus.is_in_turn_p1 !== 1'b1 || bus.active_player !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_p1: got p1=%b ap=%b expected 1 0", bus.is_in_turn_p1, bus.active_player);
    end
  endtask

  task automatic test_hits();
    do_fire();
    resolve(1'b0, 1'b1);
    tests_run++;
    if (bus.hp_p2 !== 3'd1 || bus.game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_p2_first: got hp_p2=%0d go=%b expected 1 0", bus.hp_p2, bus.game_over);
    end
    tick(); tick();
    tests_run++;
    if (bus.is_in_turn_p2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL p2_after_hit: got p2=%b expected 1", bus.is_in_turn_p2);
    end
    do_fire();
    resolve(1'b0, 1'b0);
    tick(); tick();
    do_fire();
    resolve(1'b0, 1'b1);
    tests_run++;
    if ({bus.hp_p1, bus.hp_p2, bus.game_over, bus.winner} !== {3'd2, 3'd0, 1'b1, 2'b01}) begin
      tests_failed++;
      $display("FAIL p1_wins: got hp=%0d/%0d go=%b win=%b expected 2/0 1 01",
               bus.hp_p1, bus.hp_p2, bus.game_over, bus.winner);
    end
    tick();
    tests_run++;
    if (bus.game_over !== 1'b1 || bus.is_in_turn_p1 !== 1'b0 || bus.is_in_turn_p2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL game_over_hold: got go=%b p1=%b p2=%b expected 1 0 0",
               bus.game_over, bus.is_in_turn_p1, bus.is_in_turn_p2);
    end
  endtask

  task automatic test_restart_draw();
    bus.keycode = 8'd40;
    tick();
    bus.keycode = 8'd0;
    tests_run++;
    if ({bus.hp_p1, bus.hp_p2, bus.winner, bus.game_over, bus.is_in_turn_p1} !== {3'd2, 3'd2, 2'b00, 2'b01}) begin
      tests_failed++;
      $display("FAIL restart: got hp=%0d/%0d win=%b go=%b p1=%b expected 2/2 00 0 1",
               bus.hp_p1, bus.hp_p2, bus.winner, bus.game_over, bus.is_in_turn_p1);
    end
    for (int k = 0; k < 15; k++) tick();
    tests_run++;
    if (bus.sec_left !== 6'd0 || bus.is_in_turn_p1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL last_frame: got sec=%0d p1=%b expected 0 1", bus.sec_left, bus.is_in_turn_p1);
    end
    bus.keycode = 8'd44;
    tick();
    bus.keycode = 8'd0;
    tests_run++;
    if (bus.fire !== 1'b1 || bus.is_in_turn_p1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL fire_beats_timeout: got fire=%b p1=%b expected 1 0", bus.fire, bus.is_in_turn_p1);
    end
    resolve(1'b1, 1'b0);
    tick(); tick();
    do_fire();
    resolve(1'b0, 1'b1);
    tests_run++;
    if (bus.hp_p1 !== 3'd1 || bus.hp_p2 !== 3'd1) begin
      tests_failed++;
      $display("FAIL hp_one_one: got hp=%0d/%0d expected 1/1", bus.hp_p1, bus.hp_p2);
    end
    tick(); tick();
    do_fire();
    resolve(1'b1, 1'b1);
    tests_run++;
    if ({bus.hp_p1, bus.hp_p2, bus.game_over, bus.winner} !== {3'd0, 3'd0, 1'b1, 2'b11}) begin
      tests_failed++;
      $display("FAIL draw: got hp=%0d/%0d go=%b win=%b expected 0/0 1 11",
               bus.hp_p1, bus.hp_p2, bus.game_over, bus.winner);
    end
    bus.keycode = 8'd40;
    tick();
    bus.keycode = 8'd0;
    tests_run++;
    if ({bus.hp_p1, bus.hp_p2, bus.is_in_turn_p1, bus.active_player, bus.winner, bus.sec_left}
        !== {3'd2, 3'd2, 1'b1, 1'b0, 2'b00, 6'd3}) begin
      tests_failed++;
      $display("FAIL restart_after_draw: got hp=%0d/%0d p1=%b ap=%b win=%b sec=%0d expected 2/2 1 0 00 3",
               bus.hp_p1, bus.hp_p2, bus.is_in_turn_p1, bus.active_player, bus.winner, bus.sec_left);
    end
  endtask

  task automatic test_reset_in_proj();
    do_fire();
    resolve(1'b0, 1'b1);
    tick(); tick();
    bus.keycode = 8'd44;
    tick();
    tests_run++;
    if (bus.fire !== 1'b1 || bus.hp_p2 !== 3'd1) begin
      tests_failed++;
      $display("FAIL proj_setup: got fire=%b hp_p2=%0d expected 1 1", bus.fire, bus.hp_p2);
    end
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.fire, bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player, bus.game_over} !== 5'b00000 ||
        bus.hp_p1 !== 3'd2 || bus.hp_p2 !== 3'd2 || bus.sec_left !== 6'd3) begin
      tests_failed++;
      $display("FAIL reset_in_proj: got fire=%b p1=%b p2=%b ap=%b hp=%0d/%0d sec=%0d expected 0 0 0 0 2/2 3",
               bus.fire, bus.is_in_turn_p1, bus.is_in_turn_p2, bus.active_player,
               bus.hp_p1, bus.hp_p2, bus.sec_left);
    end
    bus.keycode = 8'd0;
    tick();
    Reset_n = 1'b1;
    bus.keycode = 8'd40;
    tick();
    bus.keycode = 8'd0;
    tests_run++;
    if (bus.is_in_turn_p1 !== 1'b1 || bus.active_player !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_after_reset: got p1=%b ap=%b expected 1 0", bus.is_in_turn_p1, bus.active_player);
    end
  endtask

  initial begin
    bus.keycode   = 8'd0;
    bus.proj_done = 1'b0;
    bus.hit_p1    = 1'b0;
    bus.hit_p2    = 1'b0;
    test_reset();
    test_start();
    test_timeout();
    test_fire_held();
    test_hits();
    test_restart_draw();
    test_reset_in_proj();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
